wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 8×16-bit register file. Two producers, the ALU and the load unit, compete for the file's single write port. The block grants one per cycle with round-robin fairness and drives a registered write (write enable, address, data) into the register file. It also keeps a per-register busy scoreboard so that issue logic can detect read-after-write and write-after-write hazards on registers with writes still outstanding.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_scoreboard.sv | 45 ++++
 rtl/wb_arbiter.sv | 111 +++++++++++
 tb/tb_wb_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back arbiter and its scoreboard.
package wb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    // Requester indices; also the rr_ptr encoding of which requester has priority.
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    typedef struct packed {
        logic alu;
        logic ld;
    } req_pair_t;

    function automatic logic [1:0] pack_req(input req_pair_t r);
        logic [1:0] v;
        v          = '0;
        v[REQ_ALU] = r.alu;
        v[REQ_LD]  = r.ld;
        return v;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard: set on issue claim, cleared on commit, with hazard lookup.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] qa_i,
    input  logic [ADDR_W-1:0] qb_i,
    output logic [NREG-1:0]   busy_o,
    output logic              hazard_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a fresh claim survives a same-cycle commit.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign hazard_o = busy_q[qa_i] | busy_q[qb_i] | (set_en_i & busy_q[set_addr_i]);

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs load) driving a registered register-file write.
//   rr_ptr | meaning
//   REQ_ALU | ALU wins the next contested cycle
//   REQ_LD  | load wins the next contested cycle
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic [ADDR_W-1:0] qa,
    input  logic [ADDR_W-1:0] qb,
    output logic [NREG-1:0]   busy,
    output logic              hazard
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              xfer;
    logic              rr_q;
    logic              rr_d;
    logic              regwrite_q;
    logic              regwrite_d;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    req_pair_t         req_raw;

    // Requests are masked by reset so neither ready can rise while reset_n is low.
    assign req_raw.alu = alu_valid;
    assign req_raw.ld  = ld_valid;
    assign req         = pack_req(req_raw) & {2{reset_n}};

    always_comb begin
        gnt  = '0;
        rr_d = rr_q;
        if (&req) begin
            gnt[rr_q] = 1'b1;
            rr_d      = ~rr_q;
        end else begin
            gnt = req;
        end
    end

    assign alu_ready = gnt[REQ_ALU];
    assign ld_ready  = gnt[REQ_LD];
    assign xfer      = |gnt;

    always_comb begin
        regwrite_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (xfer) begin
            regwrite_d = 1'b1;
            waddr_d    = gnt[REQ_LD] ? ld_addr : alu_addr;
            wdata_d    = gnt[REQ_LD] ? ld_data : alu_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_q       <= REQ_ALU;
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            rr_q       <= rr_d;
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign RegWrite   = regwrite_q;
    assign write_addr = waddr_q;
    assign write_data = wdata_q;

    wb_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_scoreboard (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .set_en_i   (mark_valid),
        .set_addr_i (mark_addr),
        .clr_en_i   (regwrite_q),
        .clr_addr_i (waddr_q),
        .qa_i       (qa),
        .qb_i       (qb),
        .busy_o     (busy),
        .hazard_o   (hazard)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued at grant time and a monitor checks commits.
module tb_wb_arbiter;

    logic        clock;
    logic        reset_n;
    logic        alu_valid;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        RegWrite;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic        mark_valid;
    logic [2:0]  mark_addr;
    logic [2:0]  qa;
    logic [2:0]  qb;
    logic [7:0]  busy;
    logic        hazard;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  vec_cnt = 0;
    int  err_cnt = 0;

    wb_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .RegWrite   (RegWrite),
        .write_addr (write_addr),
        .write_data (write_data),
        .mark_valid (mark_valid),
        .mark_addr  (mark_addr),
        .qa         (qa),
        .qb         (qb),
        .busy       (busy),
        .hazard     (hazard)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: every committed write must match the oldest expected write.
    always @(negedge clock) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none at %0t",
                         write_addr, write_data, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {29'd0, write_addr}, {29'd0, e.a});
                chk("wr_data", {16'd0, write_data}, {16'd0, e.d});
            end
        end
    end

    task automatic step(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                        input logic lv, input logic [2:0] la, input logic [15:0] ldd,
                        input logic mv, input logic [2:0] ma,
                        input logic [2:0] a_q, input logic [2:0] b_q,
                        input logic ea, input logic el, input logic push);
        @(posedge clock);
        #1;
        alu_valid  = av;  alu_addr = aa; alu_data = ad;
        ld_valid   = lv;  ld_addr  = la; ld_data  = ldd;
        mark_valid = mv;  mark_addr = ma;
        qa         = a_q; qb = b_q;
        @(negedge clock);
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, ea});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, el});
        if (push && ea) exp_q.push_back({aa, ad});
        else if (push && el) exp_q.push_back({la, ldd});
    endtask

    task automatic idle(input logic mv, input logic [2:0] ma, input logic [2:0] a_q, input logic [2:0] b_q);
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, mv, ma, a_q, b_q, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h1111;
        ld_valid  = 1'b1; ld_addr  = 3'd2; ld_data  = 16'h2222;
        mark_valid = 1'b1; mark_addr = 3'd3; qa = 3'd0; qb = 3'd0;
        repeat (2) @(negedge clock);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_waddr", {29'd0, write_addr}, 32'd0);
        chk("rst_wdata", {16'd0, write_data}, 32'd0);
        chk("rst_busy", {24'd0, busy}, 32'd0);
        alu_valid = 1'b0; ld_valid = 1'b0; mark_valid = 1'b0;
        reset_n = 1'b1;

        // ALU alone
        step(1, 3'd3, 16'h1234, 0, 3'd0, 16'h0, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1);
        // Contention: ALU, load, ALU, load
        step(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1);
        step(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 0, 3'd0, 3'd0, 3'd0, 0, 1, 1);
        step(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1);
        step(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 0, 3'd0, 3'd0, 3'd0, 0, 1, 1);
        idle(0, 3'd0, 3'd0, 3'd0);

        // Scoreboard: claim r5, then load commits r5
        idle(1, 3'd5, 3'd0, 3'd0);
        chk("pre_mark_busy", {24'd0, busy}, 32'h00);
        chk("pre_mark_hazard", {31'd0, hazard}, 32'd0);
        step(0, 3'd0, 16'h0, 1, 3'd5, 16'hBEEF, 0, 3'd0, 3'd5, 3'd0, 0, 1, 1);
        chk("mark_r5_busy", {24'd0, busy}, 32'h20);
        chk("mark_r5_hazard", {31'd0, hazard}, 32'd1);
        idle(0, 3'd0, 3'd5, 3'd0);
        chk("commit_cycle_busy", {24'd0, busy}, 32'h20);
        idle(0, 3'd0, 3'd5, 3'd0);
        chk("t2_busy", {24'd0, busy}, 32'h00);
        chk("t2_hazard", {31'd0, hazard}, 32'd0);

        // Duplicate claim and qb hazard on r6
        idle(1, 3'd6, 3'd0, 3'd0);
        chk("r6_first_hazard", {31'd0, hazard}, 32'd0);
        idle(1, 3'd6, 3'd0, 3'd0);
        chk("r6_busy", {24'd0, busy}, 32'h40);
        chk("dup_claim_hazard", {31'd0, hazard}, 32'd1);
        step(1, 3'd6, 16'h0606, 0, 3'd0, 16'h0, 0, 3'd0, 3'd0, 3'd6, 1, 0, 1);
        chk("qb_hazard", {31'd0, hazard}, 32'd1);
        idle(0, 3'd0, 3'd0, 3'd6);
        chk("r6_commit_busy", {24'd0, busy}, 32'h40);
        idle(0, 3'd0, 3'd0, 3'd6);
        chk("r6_clear_busy", {24'd0, busy}, 32'h00);
        chk("r6_clear_hazard", {31'd0, hazard}, 32'd0);

        // Set and clear on r4 in the same cycle: set wins
        step(1, 3'd4, 16'h4444, 0, 3'd0, 16'h0, 1, 3'd4, 3'd0, 3'd0, 1, 0, 1);
        idle(1, 3'd4, 3'd0, 3'd0);
        chk("r4_busy_commit", {24'd0, busy}, 32'h10);
        idle(0, 3'd0, 3'd4, 3'd0);
        chk("set_wins_busy", {24'd0, busy}, 32'h10);
        chk("set_wins_hazard", {31'd0, hazard}, 32'd1);

        // Held load request loses once, then wins exactly once
        step(1, 3'd7, 16'h7777, 1, 3'd0, 16'h0F0F, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1);
        step(1, 3'd3, 16'h3333, 1, 3'd0, 16'h0F0F, 0, 3'd0, 3'd0, 3'd0, 0, 1, 1);
        step(1, 3'd3, 16'h3333, 0, 3'd0, 16'h0F0F, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1);
        idle(0, 3'd0, 3'd0, 3'd0);
        idle(0, 3'd0, 3'd0, 3'd0);

        // Reset mid-operation: contested grant moves rr to load, then reset drops the write
        step(1, 3'd2, 16'h2222, 1, 3'd1, 16'h1111, 0, 3'd0, 3'd0, 3'd0, 1, 0, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("midrst_busy", {24'd0, busy}, 32'h00);
        chk("midrst_waddr", {29'd0, write_addr}, 32'd0);
        chk("midrst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);
        alu_valid = 1'b0; ld_valid = 1'b0;
        reset_n = 1'b1;
        step(1, 3'd2, 16'h2222, 1, 3'd1, 16'h1111, 0, 3'd0, 3'd0, 3'd0, 1, 0, 1);
        step(1, 3'd2, 16'h2222, 1, 3'd1, 16'h1111, 0, 3'd0, 3'd0, 3'd0, 0, 1, 1);
        idle(0, 3'd0, 3'd0, 3'd0);
        idle(0, 3'd0, 3'd0, 3'd0);
        idle(0, 3'd0, 3'd0, 3'd0);
        chk("pending_writes", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
